seq_rotl: RTL and testbench
===========================

SEQ_ROTL -- requirements
Module: seq_rotl

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits.
REQ-002 Parameter AMTW, default 3, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 mode  input  1  0 = rotate left (MSB wraps to LSB); 1 = logical shift left (zero fill at LSB).
REQ-007 a  input  WIDTH  operand, captured on accepted start.
REQ-008 amt  input  AMTW  shift count 0..WIDTH-1, captured on accepted start.
REQ-009 busy  output  1  high while a request is in progress (SHIFT or DONE state).
REQ-010 done  output  1  one-cycle pulse marking y valid for the latest request.
REQ-011 y  output  WIDTH  registered result.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; encoding is free.
REQ-013 IDLE with start=1 at edge E0: capture a into working register, amt into down-counter, mode into mode register.
REQ-014 At E0, next state SHALL be SHIFT if amt != 0, else DONE.
REQ-015 SHIFT: each edge moves the working register one position left per captured mode and decrements the counter by 1.
REQ-016 SHIFT: at the edge where the counter goes from 1 to 0, next state SHALL be DONE.
REQ-017 DONE: done=1, y = working register, for exactly one cycle; next state IDLE unconditionally.
REQ-018 Latency: done SHALL be high in the cycle following edge E0+amt (amt=0 -> the cycle right after E0; amt=7 -> after E7).
REQ-019 Exactly amt single-position steps SHALL be applied; amt=0 returns a unchanged in both modes.
REQ-020 start while busy=1 SHALL be ignored; a, amt and mode changes after E0 SHALL not affect the in-flight result.
REQ-021 start=1 in the DONE cycle SHALL be ignored; a new request is accepted no earlier than the following IDLE cycle.
REQ-022 y SHALL hold its last value from the DONE cycle until the next DONE; it SHALL not show intermediate shift values.
REQ-023 busy SHALL be combinationally decoded from state: 0 in IDLE, 1 in SHIFT and DONE.
REQ-024 Rotate mode: the result SHALL equal a rotated left by amt modulo WIDTH, i.e. the exact inverse of a right rotate by amt.
REQ-025 Logical mode: the result SHALL equal (a << amt) truncated to WIDTH bits.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, done=0, y=0, counter=0, working register=0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the request with no done pulse; the first edge after rst_n rises SHALL accept start normally.

Verification
REQ-028 rotate, a=1101_0110, amt=0 -> done in cycle after E0, y=1101_0110.
REQ-029 rotate, a=1101_0110, amt=1 -> done after E1, y=1010_1101; amt=3 -> done after E3, y=1011_0110; amt=7 -> done after E7, y=0110_1011.
REQ-030 logical, a=1101_0110, amt=3 -> y=1011_0000, done after E3.
REQ-031 amt=5 in flight, second start with a=0xFF, amt=1 asserted during SHIFT and during DONE -> both ignored, one done pulse, y=rotl5(first a).
REQ-032 rst_n low during SHIFT (amt=6, after E2) -> busy, done, y all 0 at once, no done pulse; new start after release completes correctly.
REQ-033 Back-to-back requests (start held high) -> requests accepted only in IDLE, one done pulse per request, y updated only in DONE cycles.

Source files
------------

// File: rtl/seq_rotl.sv
// Sequential rotate-left / logical-shift-left unit: applies one single-bit step
// per clock to a captured operand and reports the result with a one-cycle done pulse.
module seq_rotl #(
   parameter int WIDTH = 8,
   parameter int AMTW  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [AMTW-1:0]  amt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Handshake: a request is taken when start=1 while the unit is in IDLE
   // (busy=0); start is ignored otherwise. done is high for exactly one cycle
   // and y holds that result until the next done.
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [AMTW-1:0]  cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] step;

   // mode 0 wraps the MSB into the LSB, mode 1 fills the LSB with zero
   always_comb begin
      step = {work_q[WIDTH-2:0], (mode_q ? 1'b0 : work_q[WIDTH-1])};
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d = a;
               cnt_d  = amt;
               mode_d = mode;
               if (amt != '0) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
                  y_d     = a;
               end
            end
         end
         ST_SHIFT: begin
            work_d = step;
            cnt_d  = cnt_q - AMTW'(1);
            if (cnt_q == AMTW'(1)) begin
               state_d = ST_DONE;
               y_d     = step;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         y_q     <= y_d;
      end
   end

   assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign y         = y_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_rotl.sv
// Directed bench for seq_rotl: table of single requests plus hand-written
// sequences for overlapping starts, mid-shift reset and back-to-back requests.
module tb_seq_rotl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic [7:0] a;
   logic [2:0] amt;
   logic       busy;
   logic       done;
   logic [7:0] y;
   logic [1:0] dbg_state;

   int n_checks;
   int n_errors;

   typedef struct {
      logic       mode;
      logic [7:0] a;
      logic [2:0] amt;
      logic [7:0] exp_y;
   } vec_t;

   vec_t vecs[9];

   seq_rotl #(.WIDTH(8), .AMTW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .a         (a),
      .amt       (amt),
      .busy      (busy),
      .done      (done),
      .y         (y),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One request; checks latency, result and that done lasts a single cycle.
   task automatic run_req(input logic m, input logic [7:0] av, input logic [2:0] amv,
                          input logic [7:0] exp_y, input string tag);
      int lat;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      a     = av;
      amt   = amv;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = ~av;
      amt   = ~amv;
      mode  = ~m;
      check({tag, " busy_after_e0"}, 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(amv));
      check({tag, " y"}, 32'(y), 32'(exp_y));
      @(posedge clk);
      #1;
      check({tag, " done_width"}, 32'(done), 32'd0);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " y_hold"}, 32'(y), 32'(exp_y));
   endtask

   initial begin
      logic [7:0] bb_a[6];
      logic [7:0] bb_exp[5];
      logic [7:0] last_y;
      int pulses;
      int lat;
      logic [7:0] ycap;

      n_checks = 0;
      n_errors = 0;
      start = 1'b0;
      mode  = 1'b0;
      a     = 8'h00;
      amt   = 3'd0;
      rst_n = 1'b1;

      vecs[0] = '{1'b0, 8'hD6, 3'd0, 8'hD6};
      vecs[1] = '{1'b0, 8'hD6, 3'd1, 8'hAD};
      vecs[2] = '{1'b0, 8'hD6, 3'd3, 8'hB6};
      vecs[3] = '{1'b0, 8'hD6, 3'd7, 8'h6B};
      vecs[4] = '{1'b1, 8'hD6, 3'd3, 8'hB0};
      vecs[5] = '{1'b1, 8'hD6, 3'd0, 8'hD6};
      vecs[6] = '{1'b0, 8'h81, 3'd4, 8'h18};
      vecs[7] = '{1'b1, 8'hD6, 3'd1, 8'hAC};
      vecs[8] = '{1'b1, 8'hFF, 3'd7, 8'h80};

      // Reset values
      #3 rst_n = 1'b0;
      #2;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset y", 32'(y), 32'd0);
      check("reset state", 32'(dbg_state), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_req(vecs[i].mode, vecs[i].a, vecs[i].amt, vecs[i].exp_y, $sformatf("vec%0d", i));
      end

      // Starts during SHIFT and DONE must be ignored
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      a     = 8'hD6;
      amt   = 3'd5;
      @(posedge clk);
      #1;
      a     = 8'hFF;
      amt   = 3'd1;
      mode  = 1'b1;
      pulses = 0;
      lat    = 0;
      ycap   = 8'h00;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            lat  = c;
            ycap = y;
         end
         if (pulses > 0 && !done) start = 1'b0;
      end
      check("ovl pulses", 32'(pulses), 32'd1);
      check("ovl latency", 32'(lat), 32'd5);
      check("ovl y", 32'(ycap), 32'hDA);
      check("ovl y_hold", 32'(y), 32'hDA);
      check("ovl idle", 32'(busy), 32'd0);

      // Reset in the middle of a shift aborts without a done pulse
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      a     = 8'hD6;
      amt   = 3'd6;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy_before", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst y", 32'(y), 32'd0);
      check("rst state", 32'(dbg_state), 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         check("rst no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      run_req(1'b1, 8'h0F, 3'd2, 8'h3C, "post_rst");

      // Start held high: a new request every 4 cycles with amt=2
      bb_a[0] = 8'h81; bb_a[1] = 8'h40; bb_a[2] = 8'hC3;
      bb_a[3] = 8'h12; bb_a[4] = 8'h5A; bb_a[5] = 8'h00;
      bb_exp[0] = 8'h06; bb_exp[1] = 8'h01; bb_exp[2] = 8'h0F;
      bb_exp[3] = 8'h48; bb_exp[4] = 8'h69;
      last_y = 8'h3C;
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      amt   = 3'd2;
      a     = bb_a[0];
      @(posedge clk);
      #1 a = bb_a[0];
      for (int c = 1; c <= 19; c++) begin
         @(posedge clk);
         #1;
         if (c % 4 == 2) begin
            check($sformatf("b2b done c%0d", c), 32'(done), 32'd1);
            check($sformatf("b2b y c%0d", c), 32'(y), 32'(bb_exp[c / 4]));
            last_y = bb_exp[c / 4];
         end else begin
            check($sformatf("b2b done c%0d", c), 32'(done), 32'd0);
            check($sformatf("b2b y c%0d", c), 32'(y), 32'(last_y));
         end
         a = bb_a[(c + 1) / 4];
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      check("b2b final busy", 32'(busy), 32'd0);
      check("b2b final y", 32'(y), 32'h69);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
